// File: rtl/GENERAL_DEFS.sv
// Shared decode-stage definitions: register width, word size and pipeline control typedefs.
package GENERAL_DEFS;

   localparam int ADDR_WIDTH = 4;
   localparam int WORD       = 32;

   typedef logic stall_pipeline_sig;
   typedef logic flush_pipeline_sig;

   typedef struct packed {
      logic                  used;
      logic [ADDR_WIDTH-1:0] addr;
   } hazard_src_t;

endpackage

// File: rtl/load_use_scoreboard.sv
// Per-register countdown of bubbles still owed after a load leaves the decode/EXE register.
module load_use_scoreboard
   import GENERAL_DEFS::*;
#(
   parameter int ADDR_WIDTH   = 4,
   parameter int NUM_SRC      = 3,
   parameter int LOAD_USE_GAP = 1
) (
   input  logic                          clk_i,
   input  logic                          reset_i,
   input  logic                          set_en_i,
   input  logic [ADDR_WIDTH-1:0]         set_addr_i,
   input  logic                          advance_i,
   input  logic [NUM_SRC*ADDR_WIDTH-1:0] query_addr_i,
   output logic [NUM_SRC-1:0]            busy_o
);

   localparam int NUM_REGS = 1 << ADDR_WIDTH;
   localparam int CNT_W    = (LOAD_USE_GAP > 1) ? $clog2(LOAD_USE_GAP) : 1;
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LOAD_USE_GAP - 1);

   logic [CNT_W-1:0] cnt_q [NUM_REGS];
   logic [CNT_W-1:0] cnt_d [NUM_REGS];

   // A fresh load to a register restarts its count even if an advance happens in the same cycle.
   always_comb begin
      for (int r = 0; r < NUM_REGS; r++) begin
         cnt_d[r] = cnt_q[r];
         if (set_en_i && (set_addr_i == ADDR_WIDTH'(r))) begin
            cnt_d[r] = CNT_INIT;
         end else if (advance_i && (cnt_q[r] != '0)) begin
            cnt_d[r] = cnt_q[r] - CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         for (int r = 0; r < NUM_REGS; r++) begin
            cnt_q[r] <= '0;
         end
      end else begin
         cnt_q <= cnt_d;
      end
   end

   always_comb begin
      busy_o = '0;
      for (int k = 0; k < NUM_SRC; k++) begin
         busy_o[k] = (cnt_q[query_addr_i[k*ADDR_WIDTH +: ADDR_WIDTH]] != '0);
      end
   end

endmodule

// File: rtl/decode_issue_stage.sv
// Decode/EXE pipeline register with valid/ready handshake and parametrised load-use stalls.
// Define DECODE_PERF_CNT_EN to build saturating stall/flush performance counters.
module decode_issue_stage
   import GENERAL_DEFS::*;
#(
   parameter int ADDR_WIDTH   = 4,
   parameter int NUM_SRC      = 3,
   parameter int LOAD_USE_GAP = 1,
   parameter int PAYLOAD_W    = 128,
   parameter int PC_ADDR      = 15
) (
   input  logic                          clk_i,
   input  logic                          reset_i,
   input  logic                          valid_i,
   output logic                          ready_o,
   input  logic [NUM_SRC-1:0]            src_used_i,
   input  logic [NUM_SRC*ADDR_WIDTH-1:0] src_addr_i,
   input  logic [ADDR_WIDTH-1:0]         dest_addr_i,
   input  logic                          is_load_i,
   input  logic [PAYLOAD_W-1:0]          payload_i,
   input  flush_pipeline_sig             flush_i,
   output logic                          valid_o,
   input  logic                          ready_i,
   output logic [NUM_SRC*ADDR_WIDTH-1:0] src_addr_o,
   output logic [ADDR_WIDTH-1:0]         dest_addr_o,
   output logic                          is_load_o,
   output logic [PAYLOAD_W-1:0]          payload_o,
   output stall_pipeline_sig             stall_o,
   output logic [31:0]                   stall_cnt_o,
   output logic [31:0]                   flush_cnt_o
);

   localparam logic [ADDR_WIDTH-1:0] PC_REG = ADDR_WIDTH'(PC_ADDR);

   logic                          valid_q, valid_d;
   logic [NUM_SRC*ADDR_WIDTH-1:0] srcAddr_q, srcAddr_d;
   logic [ADDR_WIDTH-1:0]         destAddr_q, destAddr_d;
   logic                          isLoad_q, isLoad_d;
   logic [PAYLOAD_W-1:0]          payload_q, payload_d;
   logic                          hazard;
   logic                          acceptIn;
   logic                          acceptOut;
   logic [NUM_SRC-1:0]            sbBusy;
   logic [ADDR_WIDTH-1:0]         srcK;

   load_use_scoreboard #(
      .ADDR_WIDTH   (ADDR_WIDTH),
      .NUM_SRC      (NUM_SRC),
      .LOAD_USE_GAP (LOAD_USE_GAP)
   ) scoreboardInst (
      .clk_i        (clk_i),
      .reset_i      (reset_i),
      .set_en_i     (acceptOut & isLoad_q),
      .set_addr_i   (destAddr_q),
      .advance_i    (ready_i),
      .query_addr_i (src_addr_i),
      .busy_o       (sbBusy)
   );

   // The load still sitting in the output register is checked directly; older ones via the scoreboard.
   always_comb begin
      hazard = 1'b0;
      srcK   = '0;
      for (int k = 0; k < NUM_SRC; k++) begin
         srcK = src_addr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
         if (src_used_i[k] && (srcK != PC_REG)) begin
            if ((valid_q && isLoad_q && (destAddr_q == srcK)) || sbBusy[k]) begin
               hazard = 1'b1;
            end
         end
      end
   end

   assign ready_o   = !flush_i && !hazard && (!valid_q || ready_i);
   assign stall_o   = valid_i && hazard && !flush_i;
   assign acceptIn  = valid_i && ready_o;
   assign acceptOut = valid_q && ready_i && !flush_i;

   always_comb begin
      valid_d    = valid_q;
      srcAddr_d  = srcAddr_q;
      destAddr_d = destAddr_q;
      isLoad_d   = isLoad_q;
      payload_d  = payload_q;
      if (flush_i) begin
         valid_d = 1'b0;
      end else if (acceptIn) begin
         valid_d = 1'b1;
      end else if (acceptOut) begin
         valid_d = 1'b0;
      end
      if (acceptIn) begin
         srcAddr_d  = src_addr_i;
         destAddr_d = dest_addr_i;
         isLoad_d   = is_load_i;
         payload_d  = payload_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         valid_q    <= 1'b0;
         srcAddr_q  <= '0;
         destAddr_q <= '0;
         isLoad_q   <= 1'b0;
         payload_q  <= '0;
      end else begin
         valid_q    <= valid_d;
         srcAddr_q  <= srcAddr_d;
         destAddr_q <= destAddr_d;
         isLoad_q   <= isLoad_d;
         payload_q  <= payload_d;
      end
   end

   assign valid_o     = valid_q;
   assign src_addr_o  = srcAddr_q;
   assign dest_addr_o = destAddr_q;
   assign is_load_o   = isLoad_q;
   assign payload_o   = payload_q;

`ifdef DECODE_PERF_CNT_EN
   logic [31:0] stallCnt_q, stallCnt_d;
   logic [31:0] flushCnt_q, flushCnt_d;

   always_comb begin
      stallCnt_d = stallCnt_q;
      flushCnt_d = flushCnt_q;
      if (stall_o && (stallCnt_q != 32'hFFFF_FFFF)) begin
         stallCnt_d = stallCnt_q + 32'd1;
      end
      if (flush_i && valid_q && (flushCnt_q != 32'hFFFF_FFFF)) begin
         flushCnt_d = flushCnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         stallCnt_q <= 32'd0;
         flushCnt_q <= 32'd0;
      end else begin
         stallCnt_q <= stallCnt_d;
         flushCnt_q <= flushCnt_d;
      end
   end

   assign stall_cnt_o = stallCnt_q;
   assign flush_cnt_o = flushCnt_q;
`else
   assign stall_cnt_o = 32'd0;
   assign flush_cnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_decode_issue_stage.sv
// Scoreboard bench for decode_issue_stage: one instance with a one-bubble gap, one with three.
module tb_decode_issue_stage;

   typedef struct packed {
      logic [127:0] pay;
      logic [11:0]  src;
      logic [3:0]   dest;
      logic         ld;
   } exp_t;

   logic         clk;
   logic         rst;
   logic         vIn      [2];
   logic         rdyIn    [2];
   logic         flushIn  [2];
   logic         isLoadIn [2];
   logic [2:0]   usedIn   [2];
   logic [11:0]  srcIn    [2];
   logic [3:0]   destIn   [2];
   logic [127:0] payIn    [2];

   logic         rdyOut      [2];
   logic         vOut        [2];
   logic         isLoadOut   [2];
   logic         stallOut    [2];
   logic [11:0]  srcOut      [2];
   logic [3:0]   destOut     [2];
   logic [127:0] payOut      [2];
   logic [31:0]  stallCntOut [2];
   logic [31:0]  flushCntOut [2];

   exp_t q0[$];
   exp_t q1[$];
   exp_t monE;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int stallSeen [2] = '{0, 0};
   int prevAcc   [2] = '{0, 0};
   int lastGap   [2] = '{0, 0};
   int base;

   decode_issue_stage dutGap1 (
      .clk_i (clk), .reset_i (rst), .valid_i (vIn[0]), .ready_o (rdyOut[0]),
      .src_used_i (usedIn[0]), .src_addr_i (srcIn[0]), .dest_addr_i (destIn[0]),
      .is_load_i (isLoadIn[0]), .payload_i (payIn[0]), .flush_i (flushIn[0]),
      .valid_o (vOut[0]), .ready_i (rdyIn[0]), .src_addr_o (srcOut[0]),
      .dest_addr_o (destOut[0]), .is_load_o (isLoadOut[0]), .payload_o (payOut[0]),
      .stall_o (stallOut[0]), .stall_cnt_o (stallCntOut[0]), .flush_cnt_o (flushCntOut[0])
   );

   decode_issue_stage #(.LOAD_USE_GAP(3)) dutGap3 (
      .clk_i (clk), .reset_i (rst), .valid_i (vIn[1]), .ready_o (rdyOut[1]),
      .src_used_i (usedIn[1]), .src_addr_i (srcIn[1]), .dest_addr_i (destIn[1]),
      .is_load_i (isLoadIn[1]), .payload_i (payIn[1]), .flush_i (flushIn[1]),
      .valid_o (vOut[1]), .ready_i (rdyIn[1]), .src_addr_o (srcOut[1]),
      .dest_addr_o (destOut[1]), .is_load_o (isLoadOut[1]), .payload_o (payOut[1]),
      .stall_o (stallOut[1]), .stall_cnt_o (stallCntOut[1]), .flush_cnt_o (flushCntOut[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("[TB] FAIL %s: got %0h required %0h", name, act, req);
      end
   endtask

   function automatic logic [127:0] mkPay(input int id);
      mkPay = {4{32'hA500_0000 + 32'(id)}};
   endfunction

   // Monitor: every handshake at the output pops the oldest expected instruction for that DUT.
   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) begin
         if (stallOut[d]) stallSeen[d]++;
         if (!rst && vOut[d] && rdyIn[d] && !flushIn[d]) begin
            if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
               checks++;
               failures++;
               $display("[TB] FAIL dut%0d unexpected output: payload %0h with empty queue", d, payOut[d]);
            end else begin
               if (d == 0) monE = q0.pop_front();
               else        monE = q1.pop_front();
               checkOutput($sformatf("dut%0d payload", d), payOut[d], monE.pay);
               checkOutput($sformatf("dut%0d dest", d), 128'(destOut[d]), 128'(monE.dest));
               checkOutput($sformatf("dut%0d src", d), 128'(srcOut[d]), 128'(monE.src));
               checkOutput($sformatf("dut%0d is_load", d), 128'(isLoadOut[d]), 128'(monE.ld));
            end
            lastGap[d] = cyc - prevAcc[d];
            prevAcc[d] = cyc;
         end
      end
   end

   task automatic setInputs(input int d, input logic [3:0] dest, input logic [11:0] src,
                            input logic [2:0] used, input logic ld, input logic [127:0] pay);
      vIn[d] = 1'b1; destIn[d] = dest; srcIn[d] = src;
      usedIn[d] = used; isLoadIn[d] = ld; payIn[d] = pay;
   endtask

   task automatic waitAccept(input int d);
      int   waited;
      exp_t e;
      waited = 0;
      @(negedge clk);
      while (!rdyOut[d] && waited < 64) begin
         @(negedge clk);
         waited++;
      end
      if (!rdyOut[d]) begin
         checks++;
         failures++;
         $display("[TB] FAIL dut%0d accept timeout: ready_o=%0b required 1", d, rdyOut[d]);
      end else begin
         e = '{pay: payIn[d], src: srcIn[d], dest: destIn[d], ld: isLoadIn[d]};
         if (d == 0) q0.push_back(e);
         else        q1.push_back(e);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input int d, input logic [3:0] dest, input logic [11:0] src,
                                input logic [2:0] used, input logic ld, input logic [127:0] pay);
      setInputs(d, dest, src, used, ld, pay);
      waitAccept(d);
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      rst = 1'b1;
      for (int d = 0; d < 2; d++) begin
         vIn[d] = 1'b1; rdyIn[d] = 1'b1; flushIn[d] = 1'b0; isLoadIn[d] = 1'b1;
         usedIn[d] = 3'b000; srcIn[d] = 12'h321; destIn[d] = 4'd9; payIn[d] = mkPay(99);
      end
      @(posedge clk);
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         checkOutput($sformatf("reset dut%0d valid_o", d), 128'(vOut[d]), 128'd0);
         checkOutput($sformatf("reset dut%0d ready_o", d), 128'(rdyOut[d]), 128'd1);
         checkOutput($sformatf("reset dut%0d payload_o", d), payOut[d], 128'd0);
         checkOutput($sformatf("reset dut%0d dest_addr_o", d), 128'(destOut[d]), 128'd0);
         checkOutput($sformatf("reset dut%0d src_addr_o", d), 128'(srcOut[d]), 128'd0);
         checkOutput($sformatf("reset dut%0d is_load_o", d), 128'(isLoadOut[d]), 128'd0);
         checkOutput($sformatf("reset dut%0d stall_cnt_o", d), 128'(stallCntOut[d]), 128'd0);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      vIn[0] = 1'b0;
      vIn[1] = 1'b0;
      tick(1);

      // GAP=1: load r3 then r3 reader -> one stall, consumer two cycles behind the load
      base = stallSeen[0];
      applyStimulus(0, 4'd3, 12'h000, 3'b000, 1'b1, mkPay(1));
      applyStimulus(0, 4'd1, 12'h003, 3'b001, 1'b0, mkPay(2));
      vIn[0] = 1'b0;
      tick(3);
      checkOutput("gap1 stall cycles", 128'(stallSeen[0] - base), 128'd1);
      checkOutput("gap1 issue spacing", 128'(lastGap[0]), 128'd2);

      // GAP=3: load r2 then r2 reader -> three bubbles
      base = stallSeen[1];
      applyStimulus(1, 4'd2, 12'h000, 3'b000, 1'b1, mkPay(3));
      applyStimulus(1, 4'd6, 12'h002, 3'b001, 1'b0, mkPay(4));
      vIn[1] = 1'b0;
      tick(4);
      checkOutput("gap3 stall cycles", 128'(stallSeen[1] - base), 128'd3);
      checkOutput("gap3 issue spacing", 128'(lastGap[1]), 128'd4);

      // GAP=3 with EXE not ready for two cycles while the counter is pending
      base = stallSeen[1];
      applyStimulus(1, 4'd2, 12'h000, 3'b000, 1'b1, mkPay(5));
      setInputs(1, 4'd7, 12'h020, 3'b010, 1'b0, mkPay(6));
      tick(1);
      rdyIn[1] = 1'b0;
      tick(2);
      rdyIn[1] = 1'b1;
      waitAccept(1);
      vIn[1] = 1'b0;
      tick(4);
      checkOutput("gap3 ready-low stall cycles", 128'(stallSeen[1] - base), 128'd5);
      checkOutput("gap3 ready-low issue spacing", 128'(lastGap[1]), 128'd6);

      // PC reads and unused sources never stall
      base = stallSeen[0];
      applyStimulus(0, 4'd3, 12'h000, 3'b000, 1'b1, mkPay(7));
      applyStimulus(0, 4'd4, 12'h00F, 3'b001, 1'b0, mkPay(8));
      vIn[0] = 1'b0;
      tick(3);
      checkOutput("pc source spacing", 128'(lastGap[0]), 128'd1);
      applyStimulus(0, 4'd3, 12'h000, 3'b000, 1'b1, mkPay(9));
      applyStimulus(0, 4'd4, 12'h003, 3'b000, 1'b0, mkPay(10));
      vIn[0] = 1'b0;
      tick(3);
      checkOutput("unused source spacing", 128'(lastGap[0]), 128'd1);
      checkOutput("no-hazard stall cycles", 128'(stallSeen[0] - base), 128'd0);
      base = stallSeen[1];
      applyStimulus(1, 4'd3, 12'h000, 3'b000, 1'b1, mkPay(11));
      applyStimulus(1, 4'd8, 12'hF00, 3'b100, 1'b0, mkPay(12));
      vIn[1] = 1'b0;
      tick(3);
      checkOutput("gap3 pc port2 spacing", 128'(lastGap[1]), 128'd1);
      checkOutput("gap3 pc port2 stalls", 128'(stallSeen[1] - base), 128'd0);

      // Flush a load r5 held in the output register; its reader then issues freely
      rdyIn[0] = 1'b0;
      applyStimulus(0, 4'd5, 12'h000, 3'b000, 1'b1, mkPay(13));
      vIn[0] = 1'b0;
      flushIn[0] = 1'b1;
      void'(q0.pop_back());
      tick(1);
      flushIn[0] = 1'b0;
      rdyIn[0] = 1'b1;
      @(negedge clk);
      checkOutput("flush clears valid_o", 128'(vOut[0]), 128'd0);
      @(posedge clk);
      #1;
      base = stallSeen[0];
      applyStimulus(0, 4'd6, 12'h005, 3'b001, 1'b0, mkPay(14));
      vIn[0] = 1'b0;
      tick(3);
      checkOutput("post-flush r5 reader stalls", 128'(stallSeen[0] - base), 128'd0);

      // Reset in the middle of a GAP=3 stall
      applyStimulus(1, 4'd4, 12'h000, 3'b000, 1'b1, mkPay(15));
      setInputs(1, 4'd9, 12'h004, 3'b001, 1'b0, mkPay(16));
      tick(1);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      checkOutput("reset mid-stall stall_o", 128'(stallOut[1]), 128'd0);
      checkOutput("reset mid-stall valid_o", 128'(vOut[1]), 128'd0);
      checkOutput("reset mid-stall ready_o", 128'(rdyOut[1]), 128'd1);
      @(posedge clk);
      #1;
      rst = 1'b0;
      vIn[1] = 1'b0;
      tick(1);

      // Four single-bubble stalls plus one flush with a valid instruction
      for (int i = 0; i < 4; i++) begin
         applyStimulus(0, 4'(3 + i + (i > 1 ? 1 : 0)), 12'h000, 3'b000, 1'b1, mkPay(20 + 2*i));
         applyStimulus(0, 4'd1, 12'(3 + i + (i > 1 ? 1 : 0)), 3'b001, 1'b0, mkPay(21 + 2*i));
      end
      vIn[0] = 1'b0;
      tick(3);
      rdyIn[0] = 1'b0;
      applyStimulus(0, 4'd8, 12'h000, 3'b000, 1'b1, mkPay(30));
      vIn[0] = 1'b0;
      flushIn[0] = 1'b1;
      void'(q0.pop_back());
      tick(1);
      flushIn[0] = 1'b0;
      rdyIn[0] = 1'b1;
      tick(2);
      @(negedge clk);
`ifdef DECODE_PERF_CNT_EN
      checkOutput("perf stall_cnt_o", 128'(stallCntOut[0]), 128'd4);
      checkOutput("perf flush_cnt_o", 128'(flushCntOut[0]), 128'd1);
`else
      checkOutput("perf stall_cnt_o", 128'(stallCntOut[0]), 128'd0);
      checkOutput("perf flush_cnt_o", 128'(flushCntOut[0]), 128'd0);
`endif
      checkOutput("dut0 queue drained", 128'(q0.size()), 128'd0);
      checkOutput("dut1 queue drained", 128'(q1.size()), 128'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/decode_issue_stage.md
Name: decode_issue_stage

Overview:
Parametrised successor to the single-issue decode/execute boundary. It holds the decode→EXE pipeline register behind a valid/ready handshake and adds a per-register load-use scoreboard, so the bubble count after a load is set by a parameter rather than fixed at one. It sits between the decode logic (address decoder, controller, imm gen, reg file read) and EXE, and takes flush from EXE.

Parameters:
ADDR_WIDTH, 4, register address width (2**ADDR_WIDTH architectural regs)
NUM_SRC, 3, number of source-register read ports checked for hazards
LOAD_USE_GAP, 1, bubbles required between a load and its consumer; legal range is 1..8
PAYLOAD_W, 128, width of opaque decoded control+data bundle carried to EXE
PC_ADDR, 15, register address that never creates a hazard (PC reads)

Ports:
clk_i  in  1  clock
reset_i  in  1  synchronous active-high reset
valid_i  in  1  decode has an instruction
ready_o  out  1  stage accepts it this cycle
src_used_i  in  NUM_SRC  per-source "address is really read" mask
src_addr_i  in  NUM_SRC*ADDR_WIDTH  source addresses; port k is at bits [k*ADDR_WIDTH +: ADDR_WIDTH]
dest_addr_i  in  ADDR_WIDTH  destination register
is_load_i  in  1  instruction reads memory into dest
payload_i  in  PAYLOAD_W  decoded bundle (controls, immediate, reg data, PC)
flush_i  in  1  kill the younger instruction in the output register
valid_o  out  1  output register holds an instruction
ready_i  in  1  EXE accepts
src_addr_o  out  NUM_SRC*ADDR_WIDTH  registered sources, used for forwarding
dest_addr_o  out  ADDR_WIDTH  registered destination
is_load_o  out  1  registered load flag
payload_o  out  PAYLOAD_W  registered bundle
stall_o  out  1  valid_i is high but blocked by a hazard
stall_cnt_o  out  32  performance counter (see Optional Feature)
flush_cnt_o  out  32  performance counter (see Optional Feature)

Behaviour:
- Reset: valid_o=0; src_addr_o, dest_addr_o, is_load_o, payload_o=0; all scoreboard counters 0; perf counters 0. Reset overrides every other event in the same cycle.
- Hazard condition, evaluated per source k with src_used_i[k]=1 and src_addr_i[k]!=PC_ADDR:
  - (a) valid_o & is_load_o & dest_addr_o==src_k, or
  - (b) sb_cnt[src_k]!=0.
  - hazard is the OR over all such k.
- ready_o = !flush_i & !hazard & (!valid_o | ready_i).
- stall_o = valid_i & hazard & !flush_i.
- Accept-in: valid_i & ready_o. Output registers load the inputs at the clock edge, valid_o<=1. Latency is 1 cycle.
- Accept-out: valid_o & ready_i & !flush_i. If there is no accept-in in the same cycle, valid_o<=0. Simultaneous accept-in and accept-out is full throughput.
- Downstream stall (valid_o & !ready_i): output registers hold; ready_o=0.
- Flush: valid_o<=0 and no accept-in. The output-register instruction is not treated as accepted, so it never sets the scoreboard. EXE applies the same flush_i to its own register. Scoreboard counts already in flight are kept, because those loads are older than the flush.
- Scoreboard: one counter per register, 0..LOAD_USE_GAP-1.
  - On accept-out of a load, sb_cnt[dest_addr_o] <= LOAD_USE_GAP-1.
  - Otherwise, in any cycle with ready_i=1, every nonzero counter decrements by 1.
  - A set to the same register wins over a decrement.
  - Counters never wrap below 0.
- Timing with GAP=1: load in the output register and consumer at the input → consumer stalls 1 cycle, then issues, leaving one bubble. GAP=3 gives three bubbles when ready_i stays high.
- Reset mid-stall: on the next edge the stall clears and no instruction is held.

Optional Feature:
DECODE_PERF_CNT_EN
- Defined:
  - stall_cnt_o counts cycles with stall_o=1.
  - flush_cnt_o counts cycles with flush_i & valid_o.
  - Both are 32-bit, saturate at 0xFFFFFFFF, and clear on reset.
- Undefined: both ports are tied to 0 and no counter flops exist.

Decomposition:
- Shared package GENERAL_DEFS: ADDR_WIDTH and WORD constants, the existing stall_pipeline_sig and flush_pipeline_sig typedefs (used for stall_o and flush_i), and a new hazard_src_t struct {used, addr}.
- Sub-module load_use_scoreboard, parametrised by ADDR_WIDTH and LOAD_USE_GAP:
  - inputs: set_en, set_addr, advance, NUM_SRC query addresses
  - output: per-query busy vector.

Test Plan:
- Reset asserted with valid_i=1 → valid_o=0, ready_o=1 next cycle, all outputs 0.
- GAP=1: load r3 issued, next instruction reads r3 (src_used=001), ready_i=1 → stall_o=1 for exactly 1 cycle, consumer valid_o two cycles after the load's valid_o.
- GAP=3: load r2, consumer on r2 → 3 bubbles. Same scenario with ready_i low 2 cycles mid-wait → 5 total stall cycles.
- Consumer reads r15 (PC_ADDR) or has src_used=0 on r3 right after load r3 → no stall, back-to-back issue.
- flush_i while a load r5 sits in the output register → valid_o=0 next cycle; following r5 reader issues without stall.
- DECODE_PERF_CNT_EN defined, 4 stall cycles plus 1 flush → stall_cnt_o=4, flush_cnt_o=1. Macro undefined → both 0.
